// File: rtl/early_debouncer.sv
// early_debouncer: accepts the first switch edge at once, then locks out for TICKS tick pulses
// Ports: clk, reset_n (sync, active-low), sw (raw switch), tick (enable from mod-M counter),
// db_level (clean level), rise_tick/fall_tick (one-cycle edge pulses), busy (lockout active).
// Macro EARLY_DB_SYNC_EN adds a 2-flop input synchronizer; undefined, sw is used directly.
module early_debouncer #(
  parameter int TICKS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  input  logic tick,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic busy
);
  localparam int CW = $clog2(TICKS + 1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic sw_s;
`ifdef EARLY_DB_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    if (!reset_n) sync <= '0;
    else sync <= {sync[0], sw};
  assign sw_s = sync[1];
`else
  assign sw_s = sw;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      ZERO: if (sw_s) begin
        state_nx = WAIT1;
        cnt_nx = CW'(TICKS);
      end
      ONE: if (!sw_s) begin
        state_nx = WAIT0;
        cnt_nx = CW'(TICKS);
      end
      default: if (tick && cnt != '0) begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) state_nx = (state == WAIT1) ? ONE : ZERO;
      end
    endcase
  end
  // outputs are decoded from the next state so they stay registered yet change on the same edge
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= ZERO;
      cnt <= '0;
      db_level <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      db_level <= state_nx == WAIT1 || state_nx == ONE;
      rise_tick <= state == ZERO && state_nx == WAIT1;
      fall_tick <= state == ONE && state_nx == WAIT0;
      busy <= state_nx == WAIT1 || state_nx == WAIT0;
    end
endmodule
